// File: rtl/two_bit_sequencer.sv
// two_bit_sequencer: program memory, 4x2 register file and FETCH/EXEC/WB control
// driving the external result-select/error stage. Optional macro: HALT_ON_ERROR_EN.
module two_bit_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              rf_we,
  input  logic [1:0]        rf_addr,
  input  logic [1:0]        rf_data,
  input  logic [1:0]        rd_sel,
  output logic [1:0]        rd_data,
  output logic              i0,
  output logic              i1,
  output logic              a0,
  output logic              a1,
  output logic              b0,
  output logic              b1,
  input  logic              f0,
  input  logic              f1,
  input  logic              error,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        ir_op_q, ir_op_d;
  logic [1:0]        ir_dst_q, ir_dst_d;
  logic [1:0]        opa_q, opa_d;
  logic [1:0]        opb_q, opb_d;
  logic [3:0][1:0]   rf_q, rf_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              last_instr;
  logic [7:0]        fetch_w;
  logic [7:0]        mem [DEPTH];

  assign fetch_w = mem[pc_q];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_op_d    = ir_op_q;
    ir_dst_d   = ir_dst_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rf_d       = rf_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    last_instr = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (rf_we) rf_d[rf_addr] = rf_data;
        if (start) begin
          err_d   = 1'b0;
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      // Operands are read from the fetched word directly so they are already
      // registered when EXEC begins; the ALU then settles through EXEC.
      S_FETCH: begin
        ir_op_d  = fetch_w[7:6];
        ir_dst_d = fetch_w[1:0];
        opa_d    = rf_q[fetch_w[5:4]];
        opb_d    = rf_q[fetch_w[3:2]];
        state_d  = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        rf_d[ir_dst_q] = {f1, f0};
        err_d          = err_q | error;
        last_instr     = (pc_q == prog_len);
`ifdef HALT_ON_ERROR_EN
        last_instr     = last_instr | error;
`endif
        if (last_instr) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_op_q  <= '0;
      ir_dst_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rf_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_op_q  <= ir_op_d;
      ir_dst_q <= ir_dst_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rf_q     <= rf_d;
      err_q    <= err_d;
    end
  end

  // Program memory keeps its contents across reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[prog_addr] <= prog_data;
  end

  assign {i1, i0}  = ir_op_q;
  assign {a1, a0}  = opa_q;
  assign {b1, b0}  = opb_q;
  assign rd_data   = rf_q[rd_sel];
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
  assign done      = (state_q == S_DONE);
  assign err_flag  = err_q;
  assign pc        = pc_q;

endmodule

// File: doc/two_bit_sequencer.md
Name: two_bit_sequencer

Overview:
- Upstream control stage of the two-bit computer.
- Holds a small loadable program memory and a 4-entry x 2-bit register file.
- Steps through the program and drives opcode (i1:i0) and operands (a1:a0, b1:b0) into the downstream result-select/error stage (combinational: 00 NOT a, 01 AND, 10 sum, 11 diff).
- Captures that stage's f1:f0/error and writes the result back to the register file.

Parameters:
- DEPTH, 8, program memory entries.
- ADDR_W, 3, program address width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin execution at pc=0; sampled only in IDLE
- prog_len  input  ADDR_W  index of last instruction to execute
- prog_we  input  1  program memory write strobe
- prog_addr  input  ADDR_W  program write address
- prog_data  input  8  instruction {op[7:6], src_a[5:4], src_b[3:2], dst[1:0]}
- rf_we  input  1  register preload strobe
- rf_addr  input  2  preload address
- rf_data  input  2  preload data
- rd_sel  input  2  observation read select
- rd_data  output  2  rf[rd_sel], combinational
- i0, i1  output  1 each  opcode to downstream stage
- a0, a1, b0, b1  output  1 each  operands to downstream stage
- f0, f1, error  input  1 each  result and error from downstream stage
- busy  output  1  high in FETCH/EXEC/WB
- done  output  1  one-cycle pulse at program completion
- err_flag  output  1  sticky error indicator
- pc  output  ADDR_W  current program counter

Behaviour:
- Reset (asynchronous): state=IDLE, pc=0, ir=0, all rf entries=0, i/a/b outputs=0, busy=0, done=0, err_flag=0. Program memory is not reset.
- Reset asserted mid-program: abort immediately to reset values; no writeback for the interrupted instruction.
- IDLE:
  - prog_we writes mem[prog_addr]; rf_we writes rf[rf_addr].
  - If both are asserted, both writes occur.
  - start=1 clears err_flag, sets pc=0, moves to FETCH.
  - If start and rf_we are in the same cycle, the preload write still occurs.
- FETCH (1 cycle): ir <= mem[pc]; next state EXEC.
- EXEC (1 cycle): i1:i0 <= ir[7:6], a1:a0 <= rf[src_a], b1:b0 <= rf[src_b], registered on entry to EXEC. The downstream stage settles during this cycle. Next state WB.
- WB (1 cycle):
  - Sample f1:f0 and error at the end of WB.
  - rf[dst] <= {f1,f0}; err_flag <= err_flag | error.
  - If pc==prog_len: go to DONE, pc holds. Otherwise pc <= pc+1 and go to FETCH.
  - Operand outputs hold their values through WB.
- DONE (1 cycle): done=1; next state IDLE. Outputs i/a/b keep their last values.
- Timing: 3 cycles per instruction. With start sampled at edge 0, the first writeback lands at edge 3 and done is high in cycle 3N+1 for N instructions.
- Aliasing: dst may equal src_a or src_b. Operands are captured in EXEC, so the writeback uses the old values. rd_data reflects the new value the cycle after the WB edge.
- pc wrap: prog_len = DEPTH-1 runs all entries; pc never exceeds prog_len.
- Busy cycles: prog_we, rf_we and start are ignored while busy=1 or in DONE.

Optional Feature:
- Macro: HALT_ON_ERROR_EN.
- Defined: if error=1 in WB, the result is still written, err_flag is set, and the state goes to DONE regardless of pc; pc holds the faulting index.
- Undefined: error only sets sticky err_flag; execution continues to prog_len.

Test Plan:
- NOT: rf0=01, mem0=00_00_00_01, prog_len=0, start; ALU stub returns 10 -> rf1=10 at edge 3, done pulse in cycle 4, err_flag=0.
- ADD overflow: rf0=11, rf1=01, mem0=10_00_01_10; stub sum=00, error=1 -> rf2=00, err_flag=1 stays set until next start.
- Multi-instruction with alias: rf0=10, rf1=11, mem0=01_00_01_00 (AND -> r0=10), mem1=11_00_01_00 (SUB; stub diff=11, underflow error=1). Expect r0=11 and done at cycle 7; with HALT_ON_ERROR_EN, expect a stop at pc=1 with mem2 never fetched.
- Reset mid-EXEC of a 4-instruction program -> all outputs and rf zero immediately; no writeback; IDLE afterwards.
- prog_we/rf_we/start pulsed while busy -> memory, rf and pc unaffected; the program completes with the original results.
- prog_len=7 full run -> pc steps 0..7 without wrap; done at cycle 25.
